// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants and state encoding for the voice scheduler
package synth_pkg;

  // Default bank geometry; the note bank must be built with the same values.
  localparam int NUM_CHANNELS_DEF  = 16;
  localparam int NUM_BITS_KEY_DEF  = 7;
  localparam int NUM_BITS_NOTE_DEF = 18;

  // Event field widths as carried on the event handshake.
  localparam int EV_ON_W   = 1;
  localparam int EV_KEY_W  = NUM_BITS_KEY_DEF;
  localparam int EV_WORD_W = NUM_BITS_NOTE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/channel_picker.sv
// rtl/channel_picker.sv - lowest-index channel search for match, free and steal candidates
module channel_picker
  import synth_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int NUM_BITS_KEY = NUM_BITS_KEY_DEF,
  localparam int IDX_W       = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0]              gate,
  input  logic [NUM_CHANNELS-1:0]              available,
  input  logic [NUM_CHANNELS*NUM_BITS_KEY-1:0] keys,
  input  logic [NUM_BITS_KEY-1:0]              ev_key,
  output logic [IDX_W-1:0]                     match_idx,
  output logic                                 match_hit,
  output logic [IDX_W-1:0]                     free_idx,
  output logic                                 free_hit,
  output logic [IDX_W-1:0]                     steal_idx,
  output logic                                 steal_hit
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    match_idx = '0;
    match_hit = 1'b0;
    free_idx  = '0;
    free_hit  = 1'b0;
    steal_idx = '0;
    steal_hit = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (gate[i] && (keys[i*NUM_BITS_KEY +: NUM_BITS_KEY] == ev_key)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!gate[i] && available[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (!gate[i]) begin
        steal_hit = 1'b1;
        steal_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - note event allocation and per-sample register sweep for the note bank
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_CHANNELS  = NUM_CHANNELS_DEF,
  parameter int NUM_BITS_NOTE = NUM_BITS_NOTE_DEF,
  parameter int NUM_BITS_KEY  = NUM_BITS_KEY_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_on,
  input  logic [NUM_BITS_KEY-1:0]  ev_key,
  input  logic [NUM_BITS_NOTE-1:0] ev_word,
  input  logic [NUM_CHANNELS-1:0]  available,
  output logic [NUM_CHANNELS-1:0]  reg_en,
  output logic [NUM_BITS_NOTE-1:0] note_in,
  output logic [NUM_CHANNELS-1:0]  note_en,
  output logic                     ev_drop,
  output logic                     overrun
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic                       tick_pend;
  logic                       ev_on_q;
  logic [NUM_BITS_KEY-1:0]    ev_key_q;
  logic [NUM_BITS_NOTE-1:0]   ev_word_q;
  logic [NUM_BITS_KEY-1:0]    key_r  [NUM_CHANNELS];
  logic [NUM_BITS_NOTE-1:0]   word_r [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    gate;
  logic [NUM_CHANNELS*NUM_BITS_KEY-1:0] keys_flat;

  logic [IDX_W-1:0] match_idx, free_idx, steal_idx, alloc_idx;
  logic             match_hit, free_hit, steal_hit, alloc_hit;

  assign ev_ready  = (state == ST_IDLE) && !sample_tick && !tick_pend;
  assign note_en   = gate;
  assign alloc_hit = free_hit || steal_hit;
  assign alloc_idx = free_hit ? free_idx : steal_idx;

  // Flatten the key table for the picker.
  always_comb begin
    keys_flat = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      keys_flat[i*NUM_BITS_KEY +: NUM_BITS_KEY] = key_r[i];
    end
  end

  channel_picker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .NUM_BITS_KEY (NUM_BITS_KEY)
  ) u_picker (
    .gate      (gate),
    .available (available),
    .keys      (keys_flat),
    .ev_key    (ev_key_q),
    .match_idx (match_idx),
    .match_hit (match_hit),
    .free_idx  (free_idx),
    .free_hit  (free_hit),
    .steal_idx (steal_idx),
    .steal_hit (steal_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: a pending or fresh tick always beats an event in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (sample_tick || tick_pend) state_nxt = ST_SWEEP;
        else if (ev_valid)            state_nxt = ST_EXEC;
      end
      ST_EXEC:  state_nxt = ST_IDLE;
      ST_SWEEP: if (idx == LAST_IDX) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Channel table, event capture and registered sweep outputs; reg_en leads idx by
  // one edge so strobe k appears k+1 cycles after the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      tick_pend <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_key_q  <= '0;
      ev_word_q <= '0;
      gate      <= '0;
      reg_en    <= '0;
      note_in   <= '0;
      ev_drop   <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        key_r[i]  <= '0;
        word_r[i] <= '0;
      end
    end else begin
      ev_drop <= 1'b0;
      overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_tick || tick_pend) begin
            tick_pend <= 1'b0;
            idx       <= '0;
            reg_en    <= NUM_CHANNELS'(1);
            note_in   <= word_r[0];
          end else if (ev_valid) begin
            ev_on_q   <= ev_on;
            ev_key_q  <= ev_key;
            ev_word_q <= ev_word;
          end
        end
        ST_EXEC: begin
          if (sample_tick) tick_pend <= 1'b1;
          if (ev_on_q) begin
            if (match_hit) begin
              word_r[match_idx] <= ev_word_q;
            end else if (alloc_hit) begin
              key_r[alloc_idx]  <= ev_key_q;
              word_r[alloc_idx] <= ev_word_q;
              gate[alloc_idx]   <= 1'b1;
            end else begin
              ev_drop <= 1'b1;
            end
          end else if (match_hit) begin
            gate[match_idx] <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (sample_tick) overrun <= 1'b1;
          if (idx == LAST_IDX) begin
            idx     <= '0;
            reg_en  <= '0;
            note_in <= '0;
          end else begin
            idx     <= idx + IDX_W'(1);
            reg_en  <= NUM_CHANNELS'(1) << (idx + IDX_W'(1));
            note_in <= word_r[idx + IDX_W'(1)];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Voice scheduler for the FM synthesizer's polyphonic note bank: accepts note-on/note-off events over a valid/ready handshake and allocates them to the 16 note channels, with voice stealing. It drives the bank's per-channel gate levels, and on every sample tick it sweeps the bank's one-hot register-write strobes across all channels in order. The final strobe of each sweep triggers the bank's summed-output latch. It sits between the key/tuning-word front end and the note register bank.

## Interface
- NUM_CHANNELS, 16, number of voices; must match the note bank.
- NUM_BITS_NOTE, 18, tuning-word width; matches the bank's note input width.
- NUM_BITS_KEY, 7, key-number width.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- sample_tick  in  1  one-cycle pulse per audio sample; starts a sweep.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accepted when high together with ev_valid.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  NUM_BITS_KEY  key number.
- ev_word  in  NUM_BITS_NOTE  tuning word; ignored for note-off.
- available  in  NUM_CHANNELS  per-channel envelope idle, from the bank.
- reg_en  out  NUM_CHANNELS  one-hot write/advance strobe to the bank.
- note_in  out  NUM_BITS_NOTE  word written with reg_en.
- note_en  out  NUM_CHANNELS  per-channel gate level.
- ev_drop  out  1  one-cycle pulse: a note-on found no channel.
- overrun  out  1  one-cycle pulse: sample_tick arrived while a sweep was in progress.

## Operation
- Per-channel storage: key[ch], word[ch], gate[ch]. note_en is driven by gate.
- States:
  - IDLE: waiting for a tick or an event.
  - EXEC: processing the captured event; exactly 1 cycle.
  - SWEEP: stepping idx from 0 to NUM_CHANNELS-1.
- ev_ready = (state==IDLE) && !sample_tick && !tick_pend.
- IDLE transitions:
  - sample_tick or tick_pend → SWEEP, idx=0, clear tick_pend.
  - Otherwise, on handshake: capture the event → EXEC.
- EXEC, note-on, first matching rule applies:
  - (a) A channel with gate=1 and key==ev_key → retrigger: update its word.
  - (b) The lowest-index channel with gate=0 and available=1.
  - (c) Steal: the lowest-index channel with gate=0 (in release).
  - (d) Otherwise pulse ev_drop; no state change.
  - For (b) and (c): write key and word, set gate=1.
- EXEC, note-off: clear gate on the lowest-index channel with gate=1 and key==ev_key. If no channel matches, do nothing; no pulse.
- EXEC always returns to IDLE. A sample_tick seen in EXEC sets tick_pend.
- SWEEP: each cycle, registered outputs reg_en = 1<<idx and note_in = word[idx]. After idx = NUM_CHANNELS-1 → IDLE.
- A sample_tick seen in SWEEP pulses overrun and is discarded.
- Gates never change during SWEEP.
- Reset values:
  - State IDLE; tick_pend 0; idx 0.
  - key, word and gate all 0, so note_en = 0.
  - reg_en = 0, note_in = 0, ev_drop = 0, overrun = 0.
  - ev_ready = 1 once rst_n deasserts.

## Timing
- All outputs are registered except ev_ready, which is combinational from state and inputs.
- Sweep timing: a tick seen in IDLE at cycle T gives reg_en[k] high in cycle T+1+k, for k = 0..NUM_CHANNELS-1. It is back in IDLE at T+1+NUM_CHANNELS.
- Every reg_en pulse is exactly 1 cycle. note_in is valid in the same cycle as its reg_en bit.
- Event timing: handshake in cycle E → note_en/ev_drop updated at the end of E+1 → ev_ready high again in E+2.
- Tick in the same cycle as ev_valid: the tick wins and the event waits.
- Tick during EXEC: the sweep starts 1 cycle late.
- Minimum tick spacing is NUM_CHANNELS+2 cycles; closer ticks produce overrun.
- rst_n asserted mid-sweep or mid-event: immediate return to reset values. A partial sweep is abandoned, with no further reg_en.

## Structure
- Shared package synth_pkg holds:
  - the state encoding (IDLE/EXEC/SWEEP);
  - the default NUM_CHANNELS/NUM_BITS_KEY constants;
  - the event field widths.
- Sub-module channel_picker is combinational. From gate, available, key[] and ev_key it produces:
  - match_idx/match_hit;
  - free_idx/free_hit;
  - steal_idx/steal_hit.
  All are lowest-index priority.

## Test plan
- Reset, then sample_tick at cycle 10 → reg_en = 0x0001…0x8000 in cycles 11–26, note_in = 0 throughout, ev_ready low 10–26.
- Note-on key 60, word 0x1234, all available → ch0 gate set; the next sweep shows note_in = 0x1234 with reg_en[0].
- 16 note-ons (keys 40–55), then note-off key 42 with available[2]=0, then note-on key 70 → steals ch2. A 17th note-on with all gates 1 → ev_drop pulse, no gate change.
- Note-on key 60 twice with words 0x100 then 0x200 → single channel, word 0x200; note-off key 99 → no change, no pulse.
- Tick coincident with ev_valid, and a tick during EXEC → the sweep runs first or is delayed by one cycle, and the event is not lost; a tick 5 cycles into a sweep → overrun pulse.
- Assert rst_n low during cycle 6 of a sweep → reg_en and note_en go to 0 immediately; the first post-reset tick sweeps cleanly.
